// File: rtl/param_processor.sv
// Multi-cycle bus-based processor: one shared bus feeds the register file, A and IR.
// Eight opcodes (mv, mvi, add, sub, and, or, mvnz, nop) fetched from DIN under a Run/Done handshake.
module param_processor #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic          Done,
    output logic [DW-1:0] BusWires,
    output logic          Zflag,
    output logic          Cflag
);
    localparam int RB  = $clog2(NREG);
    localparam int IRW = 3 + 2 * RB;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t          state_q, state_d;
    logic [IRW-1:0]  ir_q, ir_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   g_q, g_d;
    logic            z_q, z_d;
    logic            c_q, c_d;
    logic [DW-1:0]   r_q [NREG];
    logic [DW-1:0]   r_d [NREG];

    logic [2:0]      op;
    logic [RB-1:0]   rx, ry;
    logic [NREG-1:0] rin;
    logic [NREG-1:0] sel_r;
    logic            sel_g;
    logic            a_ld;
    logic            g_ld;
    logic [DW-1:0]   bus_or;
    logic [DW:0]     alu_res;

    // Only the decoded fields of the instruction word are kept; upper bits are don't-care.
    assign op = ir_q[2:0];
    assign rx = ir_q[3 +: RB];
    assign ry = ir_q[3 + RB +: RB];

    always_comb begin
        state_d = state_q;
        Done    = 1'b0;
        rin     = '0;
        sel_r   = '0;
        sel_g   = 1'b0;
        a_ld    = 1'b0;
        g_ld    = 1'b0;
        case (state_q)
            T0: begin
                if (Run) state_d = T1;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        sel_r[ry] = 1'b1;
                        rin[rx]   = 1'b1;
                        Done      = 1'b1;
                    end
                    OP_MVI: begin
                        rin[rx] = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (!z_q) begin
                            sel_r[ry] = 1'b1;
                            rin[rx]   = 1'b1;
                        end
                        Done = 1'b1;
                    end
                    OP_NOP: begin
                        Done = 1'b1;
                    end
                    default: begin
                        sel_r[rx] = 1'b1;
                        a_ld      = 1'b1;
                    end
                endcase
            end
            T2: begin
                sel_r[ry] = 1'b1;
                g_ld      = 1'b1;
            end
            default: begin
                sel_g   = 1'b1;
                rin[rx] = 1'b1;
                Done    = 1'b1;
            end
        endcase
        if (state_q != T0) begin
            state_d = Done ? T0 : state_t'(state_q + 2'd1);
        end
    end

    // With no source selected the bus defaults to DIN, which also serves mvi.
    always_comb begin
        bus_or = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel_r[i]) bus_or = bus_or | r_q[i];
        end
        if (sel_g) begin
            BusWires = g_q;
        end else if (|sel_r) begin
            BusWires = bus_or;
        end else begin
            BusWires = DIN;
        end
    end

    // Bit DW holds the carry for add and the borrow for sub (set when A < Ry).
    always_comb begin
        case (op)
            OP_ADD:  alu_res = {1'b0, a_q} + {1'b0, BusWires};
            OP_SUB:  alu_res = {1'b0, a_q} - {1'b0, BusWires};
            OP_AND:  alu_res = {1'b0, a_q & BusWires};
            default: alu_res = {1'b0, a_q | BusWires};
        endcase
    end

    always_comb begin
        ir_d = (state_q == T0) ? DIN[IRW-1:0] : ir_q;
        a_d  = a_ld ? BusWires : a_q;
        g_d  = g_ld ? alu_res[DW-1:0] : g_q;
        z_d  = g_ld ? (alu_res[DW-1:0] == '0) : z_q;
        c_d  = g_ld ? alu_res[DW] : c_q;
        for (int i = 0; i < NREG; i++) begin
            r_d[i] = rin[i] ? BusWires : r_q[i];
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            z_q     <= z_d;
            c_q     <= c_d;
            for (int i = 0; i < NREG; i++) r_q[i] <= r_d[i];
        end
    end

    assign Zflag = z_q;
    assign Cflag = c_q;

endmodule
